// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   WORD_W / ADDR_W   : instruction word and word-address widths
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   fetch_state_e     : fetch FSM encoding (REQ, WAIT, DROP)
package instruction_fetch_unit_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // ST_REQ  : asking memory for the word at fetch_pc
  // ST_WAIT : one request granted, its data will be queued
  // ST_DROP : one request granted, its data will be thrown away
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// fetch_queue: synchronous FIFO of prefetched {pc, instr} entries.
//   clock, reset_n : clock, asynchronous active-low reset
//   push/push_data : write an entry (ignored when full unless popping too)
//   pop            : drop the head entry (ignored when empty)
//   flush          : empty the queue; wins over a same-cycle push
//   head_data      : current head entry (meaningless when empty)
//   full, empty    : occupancy flags
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // A pop frees the slot the same-cycle push needs, so push+pop on a
  // full queue both go through and occupancy stays put.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches sequential instruction words from memory
// into a small prefetch queue and presents them to the core in order.
//   clock, reset_n          : clock, asynchronous active-low reset
//   imem_req/addr/gnt       : request channel to instruction memory
//   imem_rvalid/rdata       : in-order read return (>=1 cycle after gnt)
//   redirect/redirect_pc    : control-flow change from the core
//   inst_valid/ready        : instruction handshake to the core
//   inst_data/inst_pc       : head instruction and its word address
//   fsm_state               : fetch FSM state (debug)
//
// Handshakes: a memory request transfers on a cycle with imem_req=1 and
// imem_gnt=1, and imem_addr holds while imem_req=1 and imem_gnt=0; an
// instruction transfers to the core on a cycle with inst_valid=1 and
// inst_ready=1, and inst_valid never depends on inst_ready.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                DEPTH    = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [WORD_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output fetch_state_e      fsm_state
);

  fetch_state_e                 state_q;
  fetch_state_e                 state_d;
  logic [ADDR_W-1:0]            fetch_pc_q;
  logic [ADDR_W-1:0]            fetch_pc_d;
  logic                         q_full;
  logic                         q_empty;
  logic                         q_push;
  logic                         q_pop;
  logic [ADDR_W+WORD_W-1:0]     q_head;
  logic                         gnt_taken;

  // reset_n gates the request so it is low throughout reset and rises in
  // the very first cycle after release.
  assign imem_req  = reset_n & (state_q == ST_REQ) & ~q_full;
  assign imem_addr = fetch_pc_q;
  assign gnt_taken = imem_req & imem_gnt;

  assign inst_valid = ~q_empty;
  assign q_pop      = inst_valid & inst_ready;
  // A redirect on the return cycle discards the word.
  assign q_push     = (state_q == ST_WAIT) & imem_rvalid & ~redirect;

  assign inst_pc   = q_empty ? '0 : q_head[ADDR_W+WORD_W-1:WORD_W];
  assign inst_data = q_empty ? '0 : q_head[WORD_W-1:0];
  assign fsm_state = state_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      ST_REQ: begin
        if (gnt_taken) state_d = redirect ? ST_DROP : ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect) begin
          state_d = imem_rvalid ? ST_REQ : ST_DROP;
        end else if (imem_rvalid) begin
          state_d    = ST_REQ;
          fetch_pc_d = fetch_pc_q + 1'b1;  // wraps FFFF_FFFF -> 0
        end
      end
      ST_DROP: begin
        if (imem_rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
    // Redirect overrides any sequential advance in the same cycle.
    if (redirect) fetch_pc_d = redirect_pc;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + WORD_W)
  ) u_fetch_queue (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (q_push),
    .push_data ({fetch_pc_q, imem_rdata}),
    .pop       (q_pop),
    .flush     (redirect),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic         clock;
  logic         reset_n;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         inst_valid;
  logic         inst_ready;
  logic [31:0]  inst_data;
  logic [31:0]  inst_pc;
  fetch_state_e fsm_state;

  logic [63:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  // memory model controls
  int          mem_budget = 0;
  int          mem_lat    = 1;
  bit          pending    = 0;
  int          pend_cnt   = 0;
  logic [31:0] pend_addr  = '0;

  instruction_fetch_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .fsm_state   (fsm_state)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, mem_word(pc)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Memory model: grants up to mem_budget requests, one at a time, and
  // returns data mem_lat cycles after the grant. Drives on the falling edge.
  always @(negedge clock) begin
    if (reset_n !== 1'b1) begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      pending     = 0;
    end else begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      if (pending) begin
        if (pend_cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pending     = 0;
        end else begin
          pend_cnt--;
        end
      end else if (imem_req && mem_budget > 0) begin
        imem_gnt   = 1'b1;
        pending    = 1;
        pend_addr  = imem_addr;
        pend_cnt   = mem_lat;
        mem_budget--;
      end
    end
  end

  // Monitor: every instruction the core takes is compared to the scoreboard.
  always begin
    logic [63:0] e;
    @(negedge clock);
    #3;
    if (reset_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL issue_unexpected: got pc %h, expected no issue", inst_pc);
      end else begin
        e = exp_q.pop_front();
        check("issue_pc", inst_pc, e[63:32]);
        check("issue_data", inst_data, e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_gnt(input string name);
    int n = 0;
    step();
    while (imem_gnt !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check(name, {31'd0, imem_gnt}, 32'd1);
  endtask

  initial begin
    int n;
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b1;
    mem_budget  = 4;
    mem_lat     = 1;

    // reset state
    step();
    step();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_data", inst_data, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_state", 32'(fsm_state), 32'(ST_REQ));

    // sequential fetch, core always ready
    reset_n = 1'b1;
    #1;
    check("first_req", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(32'(i)));
    wait_drain("drain_seq");
    step();
    check("seq_next_addr", imem_addr, 32'd4);
    check("seq_next_req", {31'd0, imem_req}, 32'd1);
    check("seq_empty", {31'd0, inst_valid}, 32'd0);

    // stalled core fills the queue, one pop frees one request
    step();
    reset_n    = 1'b0;
    inst_ready = 1'b0;
    step();
    reset_n    = 1'b1;
    mem_budget = 4;
    mem_lat    = 1;
    repeat (20) step();
    check("full_req", {31'd0, imem_req}, 32'd0);
    check("full_valid", {31'd0, inst_valid}, 32'd1);
    check("full_head_pc", inst_pc, 32'd0);
    check("full_head_data", inst_data, mem_word(32'd0));
    mem_budget = 1;
    exp_q.push_back(ent(32'd0));
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("refill_req", {31'd0, imem_req}, 32'd1);
    check("refill_addr", imem_addr, 32'd4);
    repeat (6) step();
    check("refull_req", {31'd0, imem_req}, 32'd0);
    for (int i = 1; i <= 4; i++) exp_q.push_back(ent(32'(i)));
    inst_ready = 1'b1;
    wait_drain("drain_full");

    // redirect while a granted request is in flight
    mem_lat    = 4;
    mem_budget = 1;
    wait_gnt("gnt_addr5");
    check("gnt_addr5_val", imem_addr, 32'd5);
    step();
    check("wait_state", 32'(fsm_state), 32'(ST_WAIT));
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    check("drop_state", 32'(fsm_state), 32'(ST_DROP));
    check("drop_req", {31'd0, imem_req}, 32'd0);
    mem_budget = 1;
    mem_lat    = 1;
    exp_q.push_back(ent(32'h40));
    n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("redir_addr", imem_addr, 32'h40);
    wait_drain("drain_redir");

    // redirect coincident with rvalid and with a pop
    inst_ready = 1'b0;
    mem_lat    = 1;
    mem_budget = 2;
    repeat (8) step();
    mem_budget = 1;
    wait_gnt("gnt_addr43");
    check("gnt_addr43_val", imem_addr, 32'h43);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h10;
    inst_ready  = 1'b1;
    exp_q.push_back(ent(32'h41));
    exp_q.push_back(ent(32'h10));
    mem_budget = 1;
    step();
    redirect = 1'b0;
    check("coinc_flushed", {31'd0, inst_valid}, 32'd0);
    check("coinc_state", 32'(fsm_state), 32'(ST_REQ));
    check("coinc_addr", imem_addr, 32'h10);
    wait_drain("drain_coinc");

    // redirect to the top of the address space, pc wraps
    step();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFF);
    check("wrap_req", {31'd0, imem_req}, 32'd1);
    exp_q.push_back(ent(32'hFFFF_FFFF));
    exp_q.push_back(ent(32'h0));
    exp_q.push_back(ent(32'h1));
    mem_budget = 3;
    wait_drain("drain_wrap");

    // reset with a request outstanding and two entries queued
    inst_ready = 1'b0;
    mem_lat    = 3;
    mem_budget = 3;
    n = 0;
    step();
    while (!(mem_budget == 0 && imem_gnt === 1'b1) && n < 100) begin
      step();
      n++;
    end
    step();
    check("pre_rst_state", 32'(fsm_state), 32'(ST_WAIT));
    check("pre_rst_valid", {31'd0, inst_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_state", 32'(fsm_state), 32'(ST_REQ));
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_pc", inst_pc, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    #1;
    check("post_rst_req", {31'd0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    mem_lat    = 1;
    mem_budget = 2;
    inst_ready = 1'b1;
    exp_q.push_back(ent(32'h0));
    exp_q.push_back(ent(32'h1));
    wait_drain("drain_post_rst");

    repeat (3) step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
